seg_scan_drv: RTL and testbench
===============================

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 16'd49_999, meaning the last count of the per-digit scan period (1 ms at 50 MHz).
REQ-002 The block SHALL have port sys_clk, input, 1, system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port data, input, 20, unsigned binary value to display.
REQ-005 The block SHALL have port point, input, 6, decimal-point enable, with bit i controlling digit i.
REQ-006 The block SHALL have port sign, input, 1, where 1 means the value is negative.
REQ-007 The block SHALL have port seg_en, input, 1, display enable.
REQ-008 The block SHALL have port sel, output, 6, one-hot active-high digit select, with bit 0 as the rightmost digit.
REQ-009 The block SHALL have port seg, output, 8, active-low segment pattern, with bit 7 as dp and bits 6..0 as g..a.

Function
REQ-010 The converter SHALL be a three-state FSM: IDLE, SHIFT and DONE.
REQ-011 In IDLE, the block SHALL latch data, point and sign, then go to SHIFT.
- Latched data SHALL be clamped to 999_999 when above 999_999.
REQ-012 In SHIFT, the block SHALL run a double-dabble binary-to-BCD conversion for exactly 20 cycles, then go to DONE.
- Each cycle: add 3 to any BCD nibble >= 5, then shift left.
REQ-013 In DONE, the block SHALL copy the six BCD digits, point and sign into the display registers atomically, then return to IDLE.
- Conversion period is 22 cycles.
- Display registers SHALL never show a partial result.
REQ-014 Input changes during SHIFT or DONE SHALL be ignored until the next IDLE latch.
REQ-015 The scan counter SHALL count 0..CNT_MAX.
- At CNT_MAX it SHALL wrap to 0 and advance the digit index 0->1->...->5->0.
REQ-016 sel and seg SHALL be registered and SHALL reflect the current digit index one cycle after the index changes.
REQ-017 The segment codes SHALL be:
- digits 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90
- blank: FF
- minus: BF
REQ-018 When point[i]=1, seg bit 7 SHALL be cleared for digit i, after blanking and sign substitution.
REQ-019 The highest significant position SHALL be max(highest nonzero BCD digit, highest set point bit, 0).
REQ-020 Digits above the highest significant position SHALL be blank.
- Digit 0 SHALL never be blank.
REQ-021 When sign=1 and the highest significant position is below 5, the digit immediately above it SHALL show minus.
- When sign=1 and the highest significant position is 5, the sign SHALL be dropped.
REQ-022 While seg_en=0:
- sel SHALL be 6'b000000 and seg SHALL be 8'hFF on the next cycle.
- The scan counter and digit index SHALL be held at 0.
- Conversion SHALL continue.
REQ-023 When seg_en rises, scanning SHALL restart at digit 0.

Reset
REQ-024 On sys_rst_n=0, sel SHALL be 6'b000000 and seg SHALL be 8'hFF.
- The FSM SHALL be in IDLE.
- The scan counter, digit index, BCD shift register and display registers SHALL all be 0.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no display update.
- After release, the first display update SHALL occur 22 cycles later.

Configuration
REQ-026 Macro SEG_BLANK_EN SHALL control blanking and sign display.
- When defined: REQ-020 and REQ-021 apply.
- When undefined: all six digits SHALL show their BCD value, including leading zeros, and sign SHALL be ignored.
- When undefined: the point behaviour of REQ-018 SHALL be unchanged.

Verification
REQ-027 Reset held, then released with seg_en=0 -> sel=000000 and seg=FF throughout.
REQ-028 data=123456, point=0, sign=0, seg_en=1, CNT_MAX=9 -> the scan shall show, in order:
- sel=000001 seg=82
- sel=000010 seg=92
- sel=000100 seg=99
- sel=001000 seg=B0
- sel=010000 seg=A4
- sel=100000 seg=F9
- then wrap to sel=000001.
REQ-029 data=42, sign=1, SEG_BLANK_EN defined -> the scan shall show:
- digit0 A4
- digit1 99
- digit2 BF
- digits 3..5 FF
REQ-030 data=5, point=000010 -> the scan shall show:
- digit0 92
- digit1 40 (zero with dp)
- digits 2..5 FF
REQ-031 data=20'hFFFFF -> clamped, so all six digits shall show 90.
REQ-032 The following mid-scan events shall have these responses:
- seg_en dropped at digit 3 -> next cycle sel=000000 seg=FF.
- seg_en restored -> the scan resumes at digit 0.
- data changed during SHIFT -> the displayed value is unchanged until the following DONE.

Source files
------------

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: six-digit multiplexed seven-segment driver.
//
// A three-state FSM (idle/shift/done) converts the clamped 20-bit input into six BCD digits
// by double-dabble. Each conversion takes 22 cycles. The result, together with the point and
// sign captured with it, is copied into the display registers in one step, so the display
// never shows a half-converted value. A scan counter steps through the digits one at a time.
// For each digit it produces a registered one-hot select and an active-low segment pattern.
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   data[19:0] in   unsigned value to display (clamped to 999_999)
//   point[5:0] in   decimal point enable, bit i -> digit i
//   sign       in   1 = value is negative
//   seg_en     in   display enable
//   sel[5:0]   out  one-hot active-high digit select, bit 0 = rightmost digit
//   seg[7:0]   out  active-low segments, bit 7 = dp, bits 6..0 = g..a
//
// Build option: define SEG_BLANK_EN to blank leading digits and show a minus sign.
// Without it, all six digits show their BCD value and sign is ignored.

module seg_scan_drv #(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  // {bcd[23:0], binary[19:0]} working register for double-dabble
  logic [43:0] shift_q, shift_d;
  logic [43:0] adj;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  lat_point_q, lat_point_d;
  logic        lat_sign_q, lat_sign_d;
  logic [23:0] disp_bcd_q, disp_bcd_d;
  logic [5:0]  disp_point_q, disp_point_d;
  logic        disp_sign_q, disp_sign_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;
  logic [19:0] data_clamp;
  logic [3:0]  cur_digit;
  logic        cur_point;
  logic [7:0]  code;

  assign data_clamp = (data > 20'd999_999) ? 20'd999_999 : data;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Conversion FSM
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    lat_point_d  = lat_point_q;
    lat_sign_d   = lat_sign_q;
    disp_bcd_d   = disp_bcd_q;
    disp_point_d = disp_point_q;
    disp_sign_d  = disp_sign_q;
    adj          = shift_q;
    unique case (state_q)
      StIdle: begin
        shift_d     = {24'd0, data_clamp};
        bit_cnt_d   = 5'd0;
        lat_point_d = point;
        lat_sign_d  = sign;
        state_d     = StShift;
      end
      StShift: begin
        for (int k = 0; k < 6; k++) begin
          if (adj[20+4*k +: 4] >= 4'd5) adj[20+4*k +: 4] = adj[20+4*k +: 4] + 4'd3;
        end
        shift_d   = {adj[42:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd19) state_d = StDone;
      end
      StDone: begin
        disp_bcd_d   = shift_q[43:20];
        disp_point_d = lat_point_q;
        disp_sign_d  = lat_sign_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan counter and digit index; held at zero while the display is disabled
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!seg_en) begin
      cnt_d = 16'd0;
      idx_d = 3'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = 16'd0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Segment pattern for the current digit
  always_comb begin
    cur_digit = 4'd0;
    cur_point = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (idx_q == 3'(k)) begin
        cur_digit = disp_bcd_q[4*k +: 4];
        cur_point = disp_point_q[k];
      end
    end
  end

`ifdef SEG_BLANK_EN
  logic [2:0] hsp;

  always_comb begin
    // Highest significant position: top nonzero digit or top point bit, at least 0
    hsp = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if (disp_bcd_q[4*k +: 4] != 4'd0 || disp_point_q[k]) hsp = 3'(k);
    end
    code = seg_code(cur_digit);
    if (idx_q > hsp) begin
      // hsp + 1 can reach 6 only when hsp = 5; idx never gets there, so the sign drops
      code = (disp_sign_q && idx_q == hsp + 3'd1) ? 8'hBF : 8'hFF;
    end
    if (cur_point) code[7] = 1'b0;
  end
`else
  logic unused_sign;
  assign unused_sign = disp_sign_q;

  always_comb begin
    code = seg_code(cur_digit);
    if (cur_point) code[7] = 1'b0;
  end
`endif

  always_comb begin
    sel_d = 6'd0;
    seg_d = 8'hFF;
    if (seg_en) begin
      sel_d = 6'd1 << idx_q;
      seg_d = code;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      shift_q      <= 44'd0;
      bit_cnt_q    <= 5'd0;
      lat_point_q  <= 6'd0;
      lat_sign_q   <= 1'b0;
      disp_bcd_q   <= 24'd0;
      disp_point_q <= 6'd0;
      disp_sign_q  <= 1'b0;
      cnt_q        <= 16'd0;
      idx_q        <= 3'd0;
      sel_q        <= 6'd0;
      seg_q        <= 8'hFF;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      lat_point_q  <= lat_point_d;
      lat_sign_q   <= lat_sign_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_point_q <= disp_point_d;
      disp_sign_q  <= disp_sign_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with CNT_MAX = 9, so each digit stays on for 10 cycles.
// The expected scan sequences depend on whether SEG_BLANK_EN is defined.

module tb_seg_scan_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned cyc;

  seg_scan_drv #(
    .CNT_MAX(16'd9)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .data     (data),
    .point    (point),
    .sign     (sign),
    .seg_en   (seg_en),
    .sel      (sel),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  // Edges since reset release: latch on cyc%22==1, display update on cyc%22==0
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp_sel, input logic [7:0] exp_seg);
    chk({tag, "/sel"}, {2'b00, sel}, {2'b00, exp_sel});
    chk({tag, "/seg"}, seg, exp_seg);
  endtask

  // Raise seg_en and follow one full scan plus the wrap; e[8*d +: 8] is digit d
  task automatic scan6(input string tag, input logic [47:0] e);
    logic [5:0] s;
    seg_en = 1'b1;
    for (int d = 0; d < 6; d++) begin
      s = 6'd1 << d;
      step(1);
      chk_out($sformatf("%s_d%0d_first", tag, d), s, e[8*d +: 8]);
      step(9);
      chk_out($sformatf("%s_d%0d_last", tag, d), s, e[8*d +: 8]);
    end
    step(1);
    chk_out({tag, "_wrap"}, 6'b000001, e[7:0]);
  endtask

  task automatic load(input logic [19:0] d, input logic [5:0] p, input logic s);
    seg_en = 1'b0;
    data   = d;
    point  = p;
    sign   = s;
    step(1);
    chk_out("disable", 6'b000000, 8'hFF);
    step(50);
  endtask

  task automatic wait_phase(input int unsigned ph);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (cyc % 22 == ph) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    assert (found) else begin
      n_fails++;
      $error("FAIL phase%0d: observed timeout expected phase reached", ph);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    seg_en = 1'b0;
    data   = 20'd123456;
    point  = 6'd0;
    sign   = 1'b0;
    step(3);
    chk_out("reset", 6'b000000, 8'hFF);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      chk_out("en_low", 6'b000000, 8'hFF);
    end

    scan6("val123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
    step(30);
    chk_out("at_digit3", 6'b001000, 8'hB0);
    seg_en = 1'b0;
    step(1);
    chk_out("en_drop", 6'b000000, 8'hFF);
    seg_en = 1'b1;
    step(1);
    chk_out("en_resume", 6'b000001, 8'h82);

    load(20'd42, 6'd0, 1'b1);
`ifdef SEG_BLANK_EN
    scan6("neg42", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});
`else
    scan6("neg42", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hA4});
`endif

    load(20'd5, 6'b000010, 1'b0);
`ifdef SEG_BLANK_EN
    scan6("pt5", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h92});
`else
    scan6("pt5", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h92});
`endif

    load(20'hFFFFF, 6'd0, 1'b0);
    scan6("clamp", {6{8'h90}});

    load(20'd100000, 6'd0, 1'b1);
    scan6("sign_drop", {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});

    load(20'd0, 6'd0, 1'b1);
`ifdef SEG_BLANK_EN
    scan6("neg0", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0});
`else
    scan6("neg0", {6{8'hC0}});
`endif

    load(20'd123456, 6'b100001, 1'b0);
    scan6("pts", {8'h79, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h02});

    load(20'd7, 6'b100000, 1'b0);
    scan6("pt_top", {8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF8});

    // Change data mid-shift: the next update still shows the old value
    load(20'd7, 6'd0, 1'b0);
    wait_phase(4);
    data = 20'd3;
    wait_phase(0);
    seg_en = 1'b1;
    step(1);
    chk_out("shift_hold", 6'b000001, 8'hF8);
    seg_en = 1'b0;
    wait_phase(0);
    seg_en = 1'b1;
    step(1);
    chk_out("shift_new", 6'b000001, 8'hB0);

    // Reset mid-conversion: outputs forced, display cleared, first update 22 edges later
    data = 20'd8;
    wait_phase(10);
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 6'b000000, 8'hFF);
    seg_en = 1'b0;
    step(2);
    chk_out("rst_hold", 6'b000000, 8'hFF);
    rst_n = 1'b1;
    step(21);
    seg_en = 1'b1;
    step(1);
    chk_out("edge22", 6'b000001, 8'hC0);
    step(1);
    chk_out("edge23", 6'b000001, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
